// File: rtl/game_pkg.sv
// Shared types and default frame constants for the level status logic.
package game_pkg;

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_PLAY  = 3'd1,
        S_DOORS = 3'd2,
        S_DYING = 3'd3,
        S_OVER  = 3'd4,
        S_WIN   = 3'd5
    } level_state_t;

    typedef logic [1:0] death_cause_t;

    localparam death_cause_t CAUSE_NONE = 2'b00;
    localparam death_cause_t CAUSE_FB   = 2'b01;
    localparam death_cause_t CAUSE_IG   = 2'b10;
    localparam death_cause_t CAUSE_BOTH = 2'b11;

    // 60 Hz frame defaults
    localparam int unsigned DEF_DEATH_FRAMES   = 60;
    localparam int unsigned DEF_DOOR_FRAMES    = 30;
    localparam int unsigned DEF_FRAMES_PER_SEC = 60;
    localparam int unsigned DEF_SEC_MAX        = 999;

    // Cause bits line up with the hazard inputs: bit 1 Icegirl, bit 0 Fireboy.
    function automatic death_cause_t cause_of(input logic fb_hz, input logic ig_hz);
        return {ig_hz, fb_hz};
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Tick counter with clear, enable and a terminal-count pulse.
// WRAP=1: counts 0..TERM-1 and wraps to 0 on the terminal step.
// WRAP=0: counts up to TERM and holds there until cleared.
module frame_timer #(
    parameter int unsigned TERM  = 60,
    parameter bit          WRAP  = 1'b0,
    parameter int unsigned CNT_W = $clog2(TERM + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TERM - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(TERM);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count; tc flags the enabled step that reaches TERM. Clear wins over enable.
    always_comb begin
        tc    = en && !clr && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = WRAP ? '0 : FULL;
            end else if (cnt_q != FULL) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/level_status_monitor.sv
// Per-level win/lose verdicts, character freeze/respawn control and HUD level timer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_WAIT  | idle after reset, characters frozen, waiting for revive
// S_PLAY  | level running, timer counting
// S_DOORS | both characters at their doors, counting consecutive frames
// S_DYING | hazard hit, death animation frames counting, frozen
// S_OVER  | level lost, gameover held until revive
// S_WIN   | level won, gamewin held until revive
module level_status_monitor
    import game_pkg::*;
#(
    parameter int unsigned DEATH_FRAMES   = DEF_DEATH_FRAMES,
    parameter int unsigned DOOR_FRAMES    = DEF_DOOR_FRAMES,
    parameter int unsigned FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
    parameter int unsigned SEC_MAX        = DEF_SEC_MAX
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       revive,
    input  logic       fb_hazard,
    input  logic       ig_hazard,
    input  logic       fb_at_door,
    input  logic       ig_at_door,
    output logic       gameover,
    output logic       gamewin,
    output logic       freeze_players,
    output logic       player_respawn,
    output logic [1:0] death_cause,
    output logic [9:0] play_seconds
);

    localparam int unsigned DEATH_W = $clog2(DEATH_FRAMES + 1);
    localparam int unsigned DOOR_W  = $clog2(DOOR_FRAMES + 1);
    localparam int unsigned FPS_W   = $clog2(FRAMES_PER_SEC + 1);
    localparam int unsigned SEC_W   = $clog2(SEC_MAX + 1);

    level_state_t state_d, state_q;

    logic         gameover_d, gameover_q;
    logic         gamewin_d, gamewin_q;
    logic         freeze_d, freeze_q;
    logic         respawn_d, respawn_q;
    death_cause_t cause_d, cause_q;

    logic               tick_live;
    logic               any_hazard;
    logic               both_door;
    logic               in_level;

    logic [DEATH_W-1:0] death_cnt;
    logic               death_tc;
    logic [DOOR_W-1:0]  door_cnt;
    logic               door_tc;
    logic [FPS_W-1:0]   fps_cnt;
    logic               fps_tc;
    logic [SEC_W-1:0]   sec_cnt;
    logic               sec_tc;

    // A tick arriving together with revive belongs to the old level and is dropped.
    assign tick_live  = frame_tick && !revive;
    assign any_hazard = fb_hazard || ig_hazard;
    assign both_door  = fb_at_door && ig_at_door;
    assign in_level   = (state_q == S_PLAY) || (state_q == S_DOORS);

    // Death animation frames; only runs while dying, reset on any other state.
    frame_timer #(
        .TERM  (DEATH_FRAMES),
        .WRAP  (1'b0),
        .CNT_W (DEATH_W)
    ) u_death_timer (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (revive || (state_q != S_DYING)),
        .en    (tick_live && (state_q == S_DYING)),
        .cnt   (death_cnt),
        .tc    (death_tc)
    );

    // Consecutive both-at-door frames; any tick without both at the door restarts the run.
    frame_timer #(
        .TERM  (DOOR_FRAMES),
        .WRAP  (1'b0),
        .CNT_W (DOOR_W)
    ) u_door_timer (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (revive || !in_level || (tick_live && !both_door)),
        .en    (tick_live && in_level && !any_hazard && both_door),
        .cnt   (door_cnt),
        .tc    (door_tc)
    );

    // Frames within the current HUD second.
    frame_timer #(
        .TERM  (FRAMES_PER_SEC),
        .WRAP  (1'b1),
        .CNT_W (FPS_W)
    ) u_fps_timer (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (revive),
        .en    (tick_live && in_level),
        .cnt   (fps_cnt),
        .tc    (fps_tc)
    );

    // Elapsed level seconds, saturating; the saturation pulse itself has no consumer.
    frame_timer #(
        .TERM  (SEC_MAX),
        .WRAP  (1'b0),
        .CNT_W (SEC_W)
    ) u_sec_timer (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (revive),
        .en    (fps_tc),
        .cnt   (sec_cnt),
        .tc    (sec_tc)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; revive overrides everything, hazard beats the door on the same tick.
    always_comb begin
        state_d = state_q;
        if (revive) begin
            state_d = S_PLAY;
        end else begin
            case (state_q)
                S_WAIT: state_d = S_WAIT;
                S_PLAY: begin
                    if (tick_live) begin
                        if (any_hazard) begin
                            state_d = S_DYING;
                        end else if (both_door) begin
                            state_d = door_tc ? S_WIN : S_DOORS;
                        end
                    end
                end
                S_DOORS: begin
                    if (tick_live) begin
                        if (any_hazard) begin
                            state_d = S_DYING;
                        end else if (both_door) begin
                            state_d = door_tc ? S_WIN : S_DOORS;
                        end else begin
                            state_d = S_PLAY;
                        end
                    end
                end
                S_DYING: begin
                    if (death_tc) begin
                        state_d = S_OVER;
                    end
                end
                S_OVER:  state_d = S_OVER;
                S_WIN:   state_d = S_WIN;
                default: state_d = S_WAIT;
            endcase
        end
    end

    // Output decode from the upcoming state so every output is a plain register.
    always_comb begin
        gameover_d = (state_d == S_OVER);
        gamewin_d  = (state_d == S_WIN);
        freeze_d   = !((state_d == S_PLAY) || (state_d == S_DOORS));
        respawn_d  = revive;
        cause_d    = cause_q;
        if (revive) begin
            cause_d = CAUSE_NONE;
        end else if (in_level && (state_d == S_DYING)) begin
            cause_d = cause_of(fb_hazard, ig_hazard);
        end
    end

    // Output registers; frozen with no verdict out of reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            gameover_q <= 1'b0;
            gamewin_q  <= 1'b0;
            freeze_q   <= 1'b1;
            respawn_q  <= 1'b0;
            cause_q    <= CAUSE_NONE;
        end else begin
            gameover_q <= gameover_d;
            gamewin_q  <= gamewin_d;
            freeze_q   <= freeze_d;
            respawn_q  <= respawn_d;
            cause_q    <= cause_d;
        end
    end

    // Invariants: verdicts exclusive, counters stay within their terminal values.
    always @(posedge Clk) begin
        if (!Reset) begin
            assert (!(gameover_q && gamewin_q));
            assert (32'(death_cnt) <= DEATH_FRAMES);
            assert (32'(door_cnt) <= DOOR_FRAMES);
            assert (32'(fps_cnt) < FRAMES_PER_SEC);
            assert (!(sec_tc && (state_q == S_WAIT)));
        end
    end

    assign gameover       = gameover_q;
    assign gamewin        = gamewin_q;
    assign freeze_players = freeze_q;
    assign player_respawn = respawn_q;
    assign death_cause    = cause_q;
    assign play_seconds   = 10'(sec_cnt);

endmodule

// File: tb/tb_level_status_monitor.sv
// Directed bench for level_status_monitor: stimulus pushes expected output snapshots,
// a negedge monitor pops and compares them.
module tb_level_status_monitor;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic       revive;
    logic       fb_hazard;
    logic       ig_hazard;
    logic       fb_at_door;
    logic       ig_at_door;
    logic       gameover;
    logic       gamewin;
    logic       freeze_players;
    logic       player_respawn;
    logic [1:0] death_cause;
    logic [9:0] play_seconds;

    level_status_monitor dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_tick     (frame_tick),
        .revive         (revive),
        .fb_hazard      (fb_hazard),
        .ig_hazard      (ig_hazard),
        .fb_at_door     (fb_at_door),
        .ig_at_door     (ig_at_door),
        .gameover       (gameover),
        .gamewin        (gamewin),
        .freeze_players (freeze_players),
        .player_respawn (player_respawn),
        .death_cause    (death_cause),
        .play_seconds   (play_seconds)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string      name;
        logic       go;
        logic       gw;
        logic       fr;
        logic       rs;
        logic [1:0] dc;
        logic [9:0] sec;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic clk1();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input bit t, input bit rv, input bit fh, input bit ih,
                         input bit fd, input bit id);
        frame_tick = t;
        revive     = rv;
        fb_hazard  = fh;
        ig_hazard  = ih;
        fb_at_door = fd;
        ig_at_door = id;
    endtask

    task automatic ticks(input int n, input bit fd, input bit id);
        drive(1'b1, 1'b0, 1'b0, 1'b0, fd, id);
        repeat (n) clk1();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic one(input bit t, input bit rv, input bit fh, input bit ih,
                       input bit fd, input bit id);
        drive(t, rv, fh, ih, fd, id);
        clk1();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_out(input string nm, input bit go, input bit gw, input bit fr,
                              input bit rs, input logic [1:0] dc, input int sec);
        exp_t e;
        e.name = nm;
        e.go   = go;
        e.gw   = gw;
        e.fr   = fr;
        e.rs   = rs;
        e.dc   = dc;
        e.sec  = 10'(sec);
        sb_q.push_back(e);
    endtask

    // Monitor: compares the registered outputs mid-cycle against the oldest expectation.
    always @(negedge Clk) begin
        if (sb_q.size() != 0) begin
            cur = sb_q.pop_front();
            n_tests++;
            if ({gameover, gamewin, freeze_players, player_respawn, death_cause, play_seconds} !==
                {cur.go, cur.gw, cur.fr, cur.rs, cur.dc, cur.sec}) begin
                n_fail++;
                $display("FAIL %s: got go=%b gw=%b frz=%b rsp=%b cause=%b sec=%0d, want go=%b gw=%b frz=%b rsp=%b cause=%b sec=%0d",
                         cur.name, gameover, gamewin, freeze_players, player_respawn, death_cause,
                         play_seconds, cur.go, cur.gw, cur.fr, cur.rs, cur.dc, cur.sec);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) clk1();
        expect_out("reset_values", 0, 0, 1, 0, 2'b00, 0);
        Reset = 1'b0;

        // Idle in WAIT with ticks on alternate cycles.
        for (int i = 0; i < 100; i++) begin
            frame_tick = i[0];
            clk1();
        end
        frame_tick = 1'b0;
        expect_out("idle_wait", 0, 0, 1, 0, 2'b00, 0);

        // Revive with a coincident tick, then respawn must drop after one cycle.
        one(1, 1, 0, 0, 0, 0);
        expect_out("revive_start", 0, 0, 0, 1, 2'b00, 0);
        clk1();
        expect_out("respawn_once", 0, 0, 0, 0, 2'b00, 0);

        ticks(125, 0, 0);
        expect_out("seconds_125", 0, 0, 0, 0, 2'b00, 2);

        // Fireboy hazard, 60 death frames, then gameover holds.
        one(1, 0, 1, 0, 0, 0);
        expect_out("fb_hazard", 0, 0, 1, 0, 2'b01, 2);
        ticks(59, 0, 0);
        expect_out("dying_59", 0, 0, 1, 0, 2'b01, 2);
        ticks(1, 0, 0);
        expect_out("over_60", 1, 0, 1, 0, 2'b01, 2);
        ticks(20, 1, 1);
        expect_out("over_hold", 1, 0, 1, 0, 2'b01, 2);

        // Revive with tick in OVER: tick must not advance the new level timer.
        one(1, 1, 0, 0, 0, 0);
        expect_out("revive_in_over", 0, 0, 0, 1, 2'b00, 0);
        ticks(59, 0, 0);
        expect_out("tick_ignored_59", 0, 0, 0, 0, 2'b00, 0);
        ticks(1, 0, 0);
        expect_out("tick_ignored_60", 0, 0, 0, 0, 2'b00, 1);

        // Door run broken after 29 frames, then a full 30-frame run wins.
        ticks(29, 1, 1);
        expect_out("door_29", 0, 0, 0, 0, 2'b00, 1);
        ticks(1, 1, 0);
        expect_out("door_drop", 0, 0, 0, 0, 2'b00, 1);
        ticks(29, 1, 1);
        expect_out("door2_29", 0, 0, 0, 0, 2'b00, 1);
        ticks(1, 1, 1);
        expect_out("door2_30_win", 0, 1, 1, 0, 2'b00, 2);
        ticks(70, 1, 1);
        expect_out("win_hold", 0, 1, 1, 0, 2'b00, 2);

        // Both hazards plus both at door on one tick: death wins.
        one(0, 1, 0, 0, 0, 0);
        expect_out("revive_in_win", 0, 0, 0, 1, 2'b00, 0);
        one(1, 0, 1, 1, 1, 1);
        expect_out("hazard_beats_door", 0, 0, 1, 0, 2'b11, 0);

        // Reset in the middle of DYING.
        ticks(5, 0, 0);
        Reset = 1'b1;
        clk1();
        expect_out("reset_in_dying", 0, 0, 1, 0, 2'b00, 0);
        Reset = 1'b0;
        ticks(10, 0, 0);
        expect_out("wait_after_reset", 0, 0, 1, 0, 2'b00, 0);

        // Hazard while in DOORS, then Icegirl-only hazard.
        one(0, 1, 0, 0, 0, 0);
        ticks(5, 1, 1);
        expect_out("in_doors", 0, 0, 0, 0, 2'b00, 0);
        one(1, 0, 1, 0, 1, 1);
        expect_out("doors_hazard", 0, 0, 1, 0, 2'b01, 0);
        one(0, 1, 0, 0, 0, 0);
        one(1, 0, 0, 1, 0, 0);
        expect_out("ig_hazard", 0, 0, 1, 0, 2'b10, 0);

        // Seconds saturation.
        one(0, 1, 0, 0, 0, 0);
        ticks(59940, 0, 0);
        expect_out("seconds_max", 0, 0, 0, 0, 2'b00, 999);
        ticks(120, 0, 0);
        expect_out("seconds_saturate", 0, 0, 0, 0, 2'b00, 999);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
            @(negedge Clk);
        end
        #2;
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations never compared, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
